// File: rtl/beta_prefetch_buffer_if.sv
// Signal bundle between the prefetch buffer, the fetch stage and the instruction memory port.
// The slave modport is the buffer's view; the master modport is the environment's view.
interface beta_prefetch_buffer_if #(
  parameter int DataWidth = 32
);
  logic                 pf_en_i;
  logic                 pf_flush_i;
  logic [DataWidth-1:0] pf_flush_addr_i;
  logic [DataWidth-1:0] pf_instr_o;
  logic [DataWidth-1:0] pf_pc_o;
  logic                 pf_valid_o;
  logic                 pf_ready_i;
  logic                 pf_busy_o;
  logic                 instr_req_o;
  logic [DataWidth-1:0] instr_addr_o;
  logic                 instr_ready_i;
  logic                 instr_valid_i;
  logic [DataWidth-1:0] instr_rdata_i;

  modport slave (
    input  pf_en_i, pf_flush_i, pf_flush_addr_i, pf_ready_i,
    input  instr_ready_i, instr_valid_i, instr_rdata_i,
    output pf_instr_o, pf_pc_o, pf_valid_o, pf_busy_o,
    output instr_req_o, instr_addr_o
  );

  modport master (
    output pf_en_i, pf_flush_i, pf_flush_addr_i, pf_ready_i,
    output instr_ready_i, instr_valid_i, instr_rdata_i,
    input  pf_instr_o, pf_pc_o, pf_valid_o, pf_busy_o,
    input  instr_req_o, instr_addr_o
  );
endinterface

// File: rtl/beta_prefetch_buffer.sv
// Instruction prefetch buffer: issues sequential word fetches ahead of consumption, queues
// {instr, pc} in a FIFO and drops responses that were in flight when a flush redirected fetch.
module beta_prefetch_buffer #(
  parameter int                   DataWidth      = 32,
  parameter int                   Depth          = 4,
  parameter int                   MaxOutstanding = 2,
  parameter logic [DataWidth-1:0] BootAddr       = {DataWidth{1'b0}}
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  beta_prefetch_buffer_if.slave pf
);
  localparam int PW = $clog2(Depth);
  localparam int CW = PW + 1;
  localparam int TW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  localparam logic [CW-1:0]        CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]        CNT_ONE   = CW'(1'b1);
  localparam logic [CW-1:0]        MAX_OUT   = CW'(MaxOutstanding);
  localparam logic [CW:0]          DEPTH_N   = (CW+1)'(Depth);
  localparam logic [TW-1:0]        TAG_LAST  = TW'(MaxOutstanding - 1);
  localparam logic [TW-1:0]        TAG_ZERO  = {TW{1'b0}};
  localparam logic [PW-1:0]        PTR_ZERO  = {PW{1'b0}};
  localparam logic [DataWidth-1:0] ADDR_STEP = DataWidth'(3'b100);
  localparam logic [DataWidth-1:0] DATA_ZERO = {DataWidth{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [DataWidth-1:0] instr_q [Depth];
  logic [DataWidth-1:0] pc_q    [Depth];
  logic [DataWidth-1:0] tag_q   [MaxOutstanding];
  logic [PW-1:0]        rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]        count_q, count_d, out_q, out_d, disc_q, disc_d;
  logic [TW-1:0]        tag_wptr_q, tag_wptr_d, tag_rptr_q, tag_rptr_d;
  logic [DataWidth-1:0] fetch_addr_q, fetch_addr_d;
  logic                 valid_s, req_s, accept_s, resp_s, push_s, pop_s;
  logic                 unused_s;

  assign unused_s = ^pf.pf_flush_addr_i[1:0];

  // The req bound keeps fifo + in-flight <= Depth, so a response never lacks a slot.
  assign valid_s  = (count_q != CNT_ZERO);
  assign req_s    = pf.pf_en_i & ~pf.pf_flush_i & (out_q < MAX_OUT) &
                    (({1'b0, count_q} + {1'b0, out_q}) < DEPTH_N);
  assign accept_s = req_s & pf.instr_ready_i;
  assign resp_s   = pf.instr_valid_i;
  assign push_s   = resp_s & (disc_q == CNT_ZERO) & ~pf.pf_flush_i;
  assign pop_s    = valid_s & pf.pf_ready_i & ~pf.pf_flush_i;

  assign pf.pf_valid_o   = valid_s;
  assign pf.pf_instr_o   = instr_q[rptr_q];
  assign pf.pf_pc_o      = pc_q[rptr_q];
  assign pf.pf_busy_o    = (out_q != CNT_ZERO) | (disc_q != CNT_ZERO);
  assign pf.instr_req_o  = req_s;
  assign pf.instr_addr_o = fetch_addr_q;

  // Next-state of pointers, counters and fetch address; flush overrides everything.
  always_comb begin
    fetch_addr_d = fetch_addr_q;
    count_d      = count_q;
    rptr_d       = rptr_q;
    wptr_d       = wptr_q;
    disc_d       = disc_q;
    out_d        = out_q;
    tag_wptr_d   = tag_wptr_q;
    tag_rptr_d   = tag_rptr_q;

    if (accept_s && !resp_s) begin
      out_d = out_q + CNT_ONE;
    end else if (!accept_s && resp_s) begin
      out_d = out_q - CNT_ONE;
    end else begin
      out_d = out_q;
    end

    if (accept_s) begin
      tag_wptr_d = (tag_wptr_q == TAG_LAST) ? TAG_ZERO : tag_wptr_q + TW'(1'b1);
    end else begin
      tag_wptr_d = tag_wptr_q;
    end
    if (resp_s) begin
      tag_rptr_d = (tag_rptr_q == TAG_LAST) ? TAG_ZERO : tag_rptr_q + TW'(1'b1);
    end else begin
      tag_rptr_d = tag_rptr_q;
    end

    if (pf.pf_flush_i) begin
      fetch_addr_d = {pf.pf_flush_addr_i[DataWidth-1:2], 2'b00};
      disc_d       = resp_s ? (out_q - CNT_ONE) : out_q;
      count_d      = CNT_ZERO;
      rptr_d       = wptr_q;
    end else begin
      fetch_addr_d = accept_s ? (fetch_addr_q + ADDR_STEP) : fetch_addr_q;
      if (resp_s && (disc_q != CNT_ZERO)) begin
        disc_d = disc_q - CNT_ONE;
      end else begin
        disc_d = disc_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      wptr_d = push_s ? (wptr_q + PW'(1'b1)) : wptr_q;
      rptr_d = pop_s  ? (rptr_q + PW'(1'b1)) : rptr_q;
    end
  end

  // Mode tracking: DRAIN while stale responses remain to be discarded.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (disc_d != CNT_ZERO)  state_d = DRAIN;
        else if (pf.pf_en_i)     state_d = RUN;
        else                     state_d = IDLE;
      end
      RUN: begin
        if (disc_d != CNT_ZERO)                      state_d = DRAIN;
        else if (!pf.pf_en_i && (out_d == CNT_ZERO)) state_d = IDLE;
        else                                         state_d = RUN;
      end
      DRAIN: begin
        if (disc_d != CNT_ZERO)                     state_d = DRAIN;
        else if (pf.pf_en_i || (out_d != CNT_ZERO)) state_d = RUN;
        else                                        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      fetch_addr_q <= BootAddr;
      count_q      <= CNT_ZERO;
      out_q        <= CNT_ZERO;
      disc_q       <= CNT_ZERO;
      rptr_q       <= PTR_ZERO;
      wptr_q       <= PTR_ZERO;
      tag_wptr_q   <= TAG_ZERO;
      tag_rptr_q   <= TAG_ZERO;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      count_q      <= count_d;
      out_q        <= out_d;
      disc_q       <= disc_d;
      rptr_q       <= rptr_d;
      wptr_q       <= wptr_d;
      tag_wptr_q   <= tag_wptr_d;
      tag_rptr_q   <= tag_rptr_d;
    end
  end

  // Storage: in-flight request PCs and the instruction FIFO.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < MaxOutstanding; i++) tag_q[i] <= DATA_ZERO;
      for (int i = 0; i < Depth; i++) begin
        instr_q[i] <= DATA_ZERO;
        pc_q[i]    <= DATA_ZERO;
      end
    end else begin
      if (accept_s) begin
        tag_q[tag_wptr_q] <= fetch_addr_q;
      end
      if (push_s) begin
        instr_q[wptr_q] <= pf.instr_rdata_i;
        pc_q[wptr_q]    <= tag_q[tag_rptr_q];
      end
    end
  end
endmodule
